shift_rows_pipe: RTL and testbench
==================================

# shift_rows_pipe

Parametrised, pipelined ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. Supports Rijndael block widths of 4, 6 or 8 columns and a per-transaction encrypt/inverse mode. It has a valid/ready handshake with a registered output and a skid buffer, so it can sit between the SubBytes/InvSubBytes and MixColumns/AddRoundKey stages of a pipelined round without creating combinational ready paths.

## Interface
Parameters:
- NB, default 4: state columns (legal values 4, 6, 8); block width BW = 32*NB bits.
- TAG_W, default 4: width of the sideband tag carried alongside each block (≥1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input block present.
- in_ready  output  1  block accepted when in_valid && in_ready; driven from a register.
- in_inv  input  1  mode: 1 = InvShiftRows, 0 = ShiftRows; sampled with the block.
- in_tag  input  TAG_W  sideband; passed through unchanged.
- din  input  [0:BW-1]  state; byte k = din[8k +: 8] = s[k mod 4][k div 4] (column-major, MSB-first numbering).
- out_valid  output  1  output block present.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- dout  output  [0:BW-1]  transformed state, same byte ordering as din.
- out_tag  output  TAG_W  tag of the block on dout.
- busy  output  1  any entry held (out_valid or skid occupied).

## Operation
- Row shift offsets C(r): NB=4 or 6 → 0,1,2,3; NB=8 → 0,1,3,4.
- ShiftRows: s'[r][c] = s[r][(c + C(r)) mod NB]. InvShiftRows: s'[r][c] = s[r][(c − C(r)) mod NB]. Modulo wrap uses NB, not 4.
- The transform is combinational on din and is captured at acceptance. Stored entries hold transformed data, tag and nothing else; mode is not stored.
- Storage: main register (drives dout/out_tag/out_valid) plus one skid register.
- States: EMPTY (main empty, skid empty), ONE (main full), FULL (main and skid full).
  - EMPTY: accept → ONE.
  - ONE: accept without drain → FULL (block goes to skid). Drain without accept → EMPTY. Accept and drain together → ONE (new block goes to main).
  - FULL: in_ready = 0. Drain → ONE (skid moves to main, skid cleared).
- in_ready = 1 exactly when skid is empty (state ≠ FULL); it is registered.
- Elaboration error if NB ∉ {4,6,8}.

## Timing
- Reset: out_valid = 0, in_ready = 1 in the cycle after rst is sampled high, busy = 0, dout = 0, out_tag = 0, skid cleared. rst high in any state discards all held blocks, including one being accepted in the same cycle.
- Latency: block accepted at edge N → out_valid = 1 with its data after edge N, i.e. visible in cycle N+1.
- Throughput: 1 block/cycle sustained while out_ready = 1.
- Back-pressure: when out_valid && !out_ready, dout and out_tag hold stable until the handshake completes. At most one more block is accepted, into the skid.
- Order is strictly FIFO. No block is dropped or duplicated.
- When in_valid is low, din, in_inv and in_tag are ignored.

## Test plan
- NB=4, ShiftRows: din = 000102030405060708090a0b0c0d0e0f, in_tag=3 → next cycle dout = 00050a0f04090e03080d02070c01060b, out_tag=3.
- NB=4, InvShiftRows on the same din → dout = 000d0a0704010e0b0805020f0c090603. Also check that the ShiftRows output fed back with in_inv=1 returns the original din.
- NB=8, byte k = k, ShiftRows → row 2 of column 0 is byte 4*3+2=0x0e and row 3 of column 0 is byte 4*4+3=0x13. Column 7 wraps: row 1 = byte 1, row 3 = byte 4*3+3=0x0f.
- Back-pressure: stream 4 tagged blocks with out_ready=0 → exactly 2 accepted, in_ready drops after the second acceptance, dout holds block 1. Raise out_ready → blocks 1..4 emerge in order, one per cycle, with alternating in_inv honoured per block.
- Simultaneous accept and drain in ONE state every cycle for 100 random blocks → busy stays 1, in_ready stays 1, outputs match the reference model with 1-cycle latency.
- Assert rst in FULL state while in_valid=1 → next cycle out_valid=0, busy=0, in_ready=1, and no stale block appears afterwards.

Source files
------------

// File: rtl/shift_rows_pipe_if.sv
// shift_rows_pipe_if
//   Handshake and data bundle around the ShiftRows pipeline stage.
//   slave  : view used by the stage itself (takes blocks in, drives results out).
//   master : view used by whatever feeds and drains the stage.
//   Signals:
//     in_valid/in_ready  input handshake
//     in_inv             1 = InvShiftRows, 0 = ShiftRows (sampled with the block)
//     in_tag/out_tag     sideband carried unchanged with each block
//     din/dout           state, byte k = [8k +: 8] = s[k mod 4][k div 4]
//     out_valid/out_ready output handshake
//     busy               stage holds at least one block
interface shift_rows_pipe_if #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) ();
   localparam int BW = 32 * NB;

   logic             in_valid;
   logic             in_ready;
   logic             in_inv;
   logic [TAG_W-1:0] in_tag;
   logic [0:BW-1]    din;
   logic             out_valid;
   logic             out_ready;
   logic [0:BW-1]    dout;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   modport slave (
      input  in_valid, in_inv, in_tag, din, out_ready,
      output in_ready, out_valid, dout, out_tag, busy
   );

   modport master (
      output in_valid, in_inv, in_tag, din, out_ready,
      input  in_ready, out_valid, dout, out_tag, busy
   );
endinterface

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   Pipelined ShiftRows / InvShiftRows for Rijndael with NB = 4, 6 or 8
//   columns. The row rotation is applied combinationally to din and the
//   result is captured on acceptance into a main output register backed by
//   a one-entry skid register, so in_ready never depends combinationally on
//   out_ready.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; discards every held block
//     bus  shift_rows_pipe_if.slave (handshakes, data, tag, busy)
module shift_rows_pipe #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   shift_rows_pipe_if.slave   bus
);
   localparam int BW = 32 * NB;

   // Only the three Rijndael block widths have defined row offsets.
   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("shift_rows_pipe: NB must be 4, 6 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Row rotation amount; the 256-bit block uses a wider spread on rows 2/3.
   function automatic int row_off_f(input int r);
      int off;
      case (r)
         0:       off = 0;
         1:       off = 1;
         2:       off = (NB == 8) ? 3 : 2;
         3:       off = (NB == 8) ? 4 : 3;
         default: off = 0;
      endcase
      return off;
   endfunction

   // Row r is rotated left (forward) or right (inverse) by row_off_f(r)
   // columns, wrapping modulo NB.
   function automatic logic [0:BW-1] shift_rows_f(input logic [0:BW-1] s,
                                                  input logic          inv);
      logic [0:BW-1] o;
      int            src;
      o = {BW{1'b0}};
      for (int c = 0; c < NB; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (inv) begin
               src = (c + NB - row_off_f(r)) % NB;
            end else begin
               src = (c + row_off_f(r)) % NB;
            end
            o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
         end
      end
      return o;
   endfunction

   state_t           state_r, state_next_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [0:BW-1]    main_data_r;
   logic [TAG_W-1:0] main_tag_r;
   logic [0:BW-1]    skid_data_r;
   logic [TAG_W-1:0] skid_tag_r;

   logic             accept_s;
   logic             drain_s;
   logic             load_main_s;
   logic             load_skid_s;
   logic             move_skid_s;
   logic [0:BW-1]    xform_s;

   assign accept_s = bus.in_valid && in_ready_r;
   assign drain_s  = out_valid_r && bus.out_ready;
   assign xform_s  = shift_rows_f(bus.din, bus.in_inv);

   // Next-state and register-load decode for the main/skid pair.
   always_comb begin
      state_next_s = state_r;
      load_main_s  = 1'b0;
      load_skid_s  = 1'b0;
      move_skid_s  = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_next_s = ST_ONE;
               load_main_s  = 1'b1;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            case ({accept_s, drain_s})
               2'b10: begin
                  state_next_s = ST_FULL;
                  load_skid_s  = 1'b1;
               end
               2'b01: begin
                  state_next_s = ST_EMPTY;
               end
               2'b11: begin
                  // Main is vacated this edge, so the new block goes straight there.
                  state_next_s = ST_ONE;
                  load_main_s  = 1'b1;
               end
               default: begin
                  state_next_s = ST_ONE;
               end
            endcase
         end
         ST_FULL: begin
            // in_ready is low here, so no acceptance can coincide with a drain.
            if (drain_s) begin
               state_next_s = ST_ONE;
               move_skid_s  = 1'b1;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         default: begin
            state_next_s = ST_EMPTY;
         end
      endcase
   end

   // State register and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s != ST_FULL);
         out_valid_r <= (state_next_s != ST_EMPTY);
         busy_r      <= (state_next_s != ST_EMPTY);
      end
   end

   // Main output register: loaded with a fresh block or promoted from skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_data_r <= {BW{1'b0}};
         main_tag_r  <= {TAG_W{1'b0}};
      end else if (load_main_s) begin
         main_data_r <= xform_s;
         main_tag_r  <= bus.in_tag;
      end else if (move_skid_s) begin
         main_data_r <= skid_data_r;
         main_tag_r  <= skid_tag_r;
      end
   end

   // Skid register: catches the one block accepted while main is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_data_r <= {BW{1'b0}};
         skid_tag_r  <= {TAG_W{1'b0}};
      end else if (load_skid_s) begin
         skid_data_r <= xform_s;
         skid_tag_r  <= bus.in_tag;
      end else if (move_skid_s) begin
         skid_data_r <= {BW{1'b0}};
         skid_tag_r  <= {TAG_W{1'b0}};
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.dout      = main_data_r;
   assign bus.out_tag   = main_tag_r;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe
//   Drives an NB=4 and an NB=8 instance in lockstep with the same handshake
//   stimulus and compares both against a queue-based reference model whose
//   transform is computed from a 2-D state array.
module tb_shift_rows_pipe;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) if4 ();
   shift_rows_pipe_if #(.NB(8), .TAG_W(TAG_W)) if8 ();

   logic             in_valid  = 1'b0;
   logic             in_inv    = 1'b0;
   logic [TAG_W-1:0] in_tag    = '0;
   logic             out_ready = 1'b0;
   logic [0:127]     din4      = '0;
   logic [0:255]     din8      = '0;

   assign if4.in_valid  = in_valid;
   assign if4.in_inv    = in_inv;
   assign if4.in_tag    = in_tag;
   assign if4.din       = din4;
   assign if4.out_ready = out_ready;
   assign if8.in_valid  = in_valid;
   assign if8.in_inv    = in_inv;
   assign if8.in_tag    = in_tag;
   assign if8.din       = din8;
   assign if8.out_ready = out_ready;

   shift_rows_pipe #(.NB(4), .TAG_W(TAG_W)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   shift_rows_pipe #(.NB(8), .TAG_W(TAG_W)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

   typedef struct {
      logic [0:127]     d4;
      logic [0:255]     d8;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, obs, exp);
      end
   endtask

   // Reference ShiftRows: unpack to s[row][col], rotate each row, repack.
   function automatic logic [0:255] ref_shift(input logic [0:255] s, input int nb, input bit inv);
      logic [7:0]   st [4][8];
      logic [0:255] o;
      int           off [4];
      int           src;
      o = '0;
      off[0] = 0;
      off[1] = 1;
      off[2] = (nb == 8) ? 3 : 2;
      off[3] = (nb == 8) ? 4 : 3;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = s[8*(4*c+r) +: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < nb; c++) begin
            src = inv ? ((c - off[r]) % nb + nb) % nb : (c + off[r]) % nb;
            o[8*(4*c+r) +: 8] = st[r][src];
         end
      return o;
   endfunction

   // One clock: check outputs against the model, advance one edge, update model.
   task automatic cycle(output bit acc, output bit obs_acc);
      entry_t e, f;
      logic [0:255] t4;
      bit drn;
      check("out_valid4", {255'b0, if4.out_valid}, {255'b0, q.size() > 0});
      check("in_ready4",  {255'b0, if4.in_ready},  {255'b0, q.size() < 2});
      check("busy4",      {255'b0, if4.busy},      {255'b0, q.size() > 0});
      check("out_valid8", {255'b0, if8.out_valid}, {255'b0, q.size() > 0});
      check("in_ready8",  {255'b0, if8.in_ready},  {255'b0, q.size() < 2});
      if (q.size() > 0) begin
         f = q[0];
         check("dout4",    {128'b0, if4.dout}, {128'b0, f.d4});
         check("out_tag4", {252'b0, if4.out_tag}, {252'b0, f.tag});
         check("dout8",    if8.dout, f.d8);
         check("out_tag8", {252'b0, if8.out_tag}, {252'b0, f.tag});
      end
      acc     = in_valid && (q.size() < 2);
      obs_acc = in_valid && if4.in_ready;
      drn     = out_ready && (q.size() > 0);
      t4      = ref_shift({din4, 128'b0}, 4, in_inv);
      e.d4    = t4[0:127];
      e.d8    = ref_shift(din8, 8, in_inv);
      e.tag   = in_tag;
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
   endtask

   task automatic rand_block();
      for (int i = 0; i < 4; i++) din4[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) din8[32*i +: 32] = $urandom;
      in_tag = TAG_W'($urandom);
      in_inv = 1'($urandom);
   endtask

   initial begin
      bit acc, oacc;
      int blk, nobs;
      logic [0:127] orig4;
      logic [0:255] orig8, d8v;

      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", {255'b0, if4.out_valid}, 256'd0);
      check("rst_in_ready",  {255'b0, if4.in_ready},  256'd1);
      check("rst_busy",      {255'b0, if4.busy},      256'd0);
      check("rst_dout",      {128'b0, if4.dout},      256'd0);
      check("rst_out_tag",   {252'b0, if4.out_tag},   256'd0);
      check("rst_dout8",     if8.dout,                256'd0);

      // Directed vectors
      orig4 = 128'h000102030405060708090a0b0c0d0e0f;
      for (int k = 0; k < 32; k++) orig8[8*k +: 8] = 8'(k);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      din4 = orig4; din8 = orig8; in_tag = 4'd3; in_inv = 1'b0;
      cycle(acc, oacc);
      check("sr4_vec", {128'b0, if4.dout}, {128'b0, 128'h00050a0f04090e03080d02070c01060b});
      check("sr4_tag", {252'b0, if4.out_tag}, 256'd3);
      d8v = if8.dout;
      check("sr8_r2c0", {248'b0, d8v[16 +: 8]},  {248'b0, 8'h0e});
      check("sr8_r3c0", {248'b0, d8v[24 +: 8]},  {248'b0, 8'h13});
      check("sr8_r1c7", {248'b0, d8v[232 +: 8]}, {248'b0, 8'h01});
      check("sr8_r3c7", {248'b0, d8v[248 +: 8]}, {248'b0, 8'h0f});
      in_inv = 1'b1; in_tag = 4'd5;
      cycle(acc, oacc);
      check("isr4_vec", {128'b0, if4.dout}, {128'b0, 128'h000d0a0704010e0b0805020f0c090603});
      din4 = 128'h00050a0f04090e03080d02070c01060b;
      din8 = ref_shift(orig8, 8, 1'b0);
      in_inv = 1'b1; in_tag = 4'd6;
      cycle(acc, oacc);
      check("round4", {128'b0, if4.dout}, {128'b0, orig4});
      check("round8", if8.dout, orig8);
      in_valid = 1'b0;
      repeat (2) cycle(acc, oacc);

      // Back-pressure: four blocks offered with the sink stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      blk = 0; nobs = 0;
      rand_block(); in_tag = 4'd1; in_inv = 1'b0;
      repeat (4) begin
         cycle(acc, oacc);
         if (oacc) nobs++;
         if (acc) begin
            blk++;
            rand_block(); in_tag = TAG_W'(blk + 1); in_inv = blk[0];
         end
      end
      check("bp_accepted", nobs, 2);
      check("bp_in_ready", {255'b0, if4.in_ready}, 256'd0);
      check("bp_hold_tag", {252'b0, if4.out_tag}, 256'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && blk < 4; k++) begin
         cycle(acc, oacc);
         if (oacc) nobs++;
         if (acc) begin
            blk++;
            rand_block(); in_tag = TAG_W'(blk + 1); in_inv = blk[0];
         end
      end
      check("bp_total", nobs, 4);
      in_valid = 1'b0;
      repeat (4) cycle(acc, oacc);

      // Sustained accept+drain for 100 blocks
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (101) begin
         rand_block();
         cycle(acc, oacc);
      end
      in_valid = 1'b0;
      repeat (2) cycle(acc, oacc);

      // Reset while FULL with a block offered
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (3) begin rand_block(); cycle(acc, oacc); end
      rst = 1'b1;
      rand_block();
      cycle(acc, oacc);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("rfull_out_valid", {255'b0, if4.out_valid}, 256'd0);
      check("rfull_busy",      {255'b0, if4.busy},      256'd0);
      check("rfull_in_ready",  {255'b0, if4.in_ready},  256'd1);
      repeat (3) cycle(acc, oacc);

      // Random traffic
      repeat (300) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rand_block();
         cycle(acc, oacc);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cycle(acc, oacc);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
